// File: rtl/rx_frame_fifo.sv
// rx_frame_fifo: FWFT circular buffer for received UART frames (data + parity/stop flags),
// with sticky overrun and optional dropping/counting of errored frames.
module rx_frame_fifo #(
    parameter int DATA_WIDTH   = 8,
    parameter int DEPTH        = 8,
    parameter bit DROP_ERRORED = 1'b0
) (
    input  logic                         RX_CLK,
    input  logic                         RX_RST,
    input  logic                         RX_WR_EN,
    input  logic [DATA_WIDTH-1:0]        RX_DATA_IN,
    input  logic                         PARITY_ERR_IN,
    input  logic                         STOP_ERR_IN,
    input  logic                         RD_READY,
    output logic                         RD_VALID,
    output logic [DATA_WIDTH-1:0]        RD_DATA,
    output logic                         RD_PARITY_ERR,
    output logic                         RD_STOP_ERR,
    output logic [$clog2(DEPTH+1)-1:0]   FIFO_COUNT,
    output logic                         FULL,
    output logic                         EMPTY,
    output logic                         OVERRUN,
    input  logic                         CLR_OVERRUN,
    output logic [7:0]                   DROP_CNT
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int EW = DATA_WIDTH + 2;

    logic [EW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full_q, full_d, empty_q, empty_d;
    logic          overrun_q, overrun_d;
    logic [7:0]    drop_cnt_q, drop_cnt_d;
    logic          err, drop, push, pop, wr_ok, ovr;
    logic [EW-1:0] head;

    always_comb begin
        err        = PARITY_ERR_IN | STOP_ERR_IN;
        drop       = RX_WR_EN & DROP_ERRORED & err;
        push       = RX_WR_EN & ~drop;
        pop        = ~empty_q & RD_READY;
        wr_ok      = push & (~full_q | pop);
        ovr        = push & full_q & ~pop;
        wr_ptr_d   = wr_ptr_q + PW'(wr_ok);
        rd_ptr_d   = rd_ptr_q + PW'(pop);
        // The extra MSB distinguishes full (MSBs differ) from empty (pointers equal).
        count_d    = CW'(wr_ptr_d - rd_ptr_d);
        full_d     = (wr_ptr_d[AW] != rd_ptr_d[AW]) && (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
        empty_d    = wr_ptr_d == rd_ptr_d;
        overrun_d  = ovr ? 1'b1 : CLR_OVERRUN ? 1'b0 : overrun_q;
        drop_cnt_d = (drop && drop_cnt_q != 8'hFF) ? drop_cnt_q + 8'd1 : drop_cnt_q;
    end

    always_ff @(posedge RX_CLK or posedge RX_RST) begin
        if (RX_RST) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overrun_q  <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            overrun_q  <= overrun_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    always_ff @(posedge RX_CLK) begin
        if (wr_ok) mem[wr_ptr_q[AW-1:0]] <= {STOP_ERR_IN, PARITY_ERR_IN, RX_DATA_IN};
    end

    assign head          = mem[rd_ptr_q[AW-1:0]];
    assign RD_VALID      = ~empty_q;
    assign RD_DATA       = head[DATA_WIDTH-1:0];
    assign RD_PARITY_ERR = head[DATA_WIDTH];
    assign RD_STOP_ERR   = head[DATA_WIDTH+1];
    assign FIFO_COUNT    = count_q;
    assign FULL          = full_q;
    assign EMPTY         = empty_q;
    assign OVERRUN       = overrun_q;
    assign DROP_CNT      = drop_cnt_q;
endmodule
